// File: rtl/ro_enc_pkg.sv
// Shared encoder codes and the quadrature step-direction helper used by every channel.
package ro_enc_pkg;

    typedef enum logic [1:0] {
        RO_ENC_NONE = 2'b00,
        RO_ENC_CW   = 2'b01,
        RO_ENC_CCW  = 2'b10,
        RO_ENC_ERR  = 2'b11
    } ro_enc_dir_e;

    // Map {a,b} onto its position in the CW cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] ro_enc_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    function automatic ro_enc_dir_e ro_enc_step_dir(input logic [1:0] prev_ab,
                                                    input logic [1:0] curr_ab);
        logic [1:0] delta;
        delta = ro_enc_pos(curr_ab) - ro_enc_pos(prev_ab);
        unique case (delta)
            2'd0:    return RO_ENC_NONE;
            2'd1:    return RO_ENC_CW;
            2'd3:    return RO_ENC_CCW;
            default: return RO_ENC_ERR;
        endcase
    endfunction

endpackage

// File: rtl/ro_enc_ch.sv
// One encoder channel: 2-FF sync, debounce, quadrature decode, detent grouping,
// saturating signed detent counter and sticky illegal-transition flag.
module ro_enc_ch
    import ro_enc_pkg::*;
#(
    parameter int unsigned DEB_CYC  = 1000,
    parameter int unsigned STEP_DET = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    intr_clear,
    output logic [1:0]              data,
    output logic signed [CNT_W-1:0] cnt,
    output logic                    err
);

    localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC);
    localparam logic signed [3:0] ACC_TOP = 4'(STEP_DET - 1);
    localparam logic signed [3:0] ACC_BOT = 4'sd0 - ACC_TOP;
    localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [1:0]              sync1_q, sync2_q;
    logic [1:0]              fill_q;
    logic [1:0]              cand_q;
    logic [DEB_W-1:0]        run_q, run_d;
    logic [1:0]              filt_q, filt_d;
    logic                    init_q, init_d;
    logic signed [3:0]       acc_q, acc_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [1:0]              data_q, data_d;
    logic                    accept;
    logic                    det_cw, det_ccw;
    ro_enc_dir_e             dir;

    // Debounce is held off until the synchroniser has flushed its reset zeros.
    always_comb begin
        run_d = run_q;
        if (fill_q[1]) begin
            if (sync2_q != cand_q) begin
                run_d = DEB_W'(1);
            end else if (run_q < DEB_MAX) begin
                run_d = run_q + DEB_W'(1);
            end
        end
        accept = fill_q[1] && (run_d == DEB_MAX) && (!init_q || (sync2_q != filt_q));
    end

    always_comb begin
        dir     = ro_enc_step_dir(filt_q, sync2_q);
        filt_d  = filt_q;
        init_d  = init_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        det_cw  = 1'b0;
        det_ccw = 1'b0;

        // Clear first so a detent or error in the same cycle still lands.
        if (intr_clear) begin
            cnt_d = '0;
            err_d = 1'b0;
        end

        if (accept) begin
            filt_d = sync2_q;
            init_d = 1'b1;
            if (init_q) begin
                unique case (dir)
                    RO_ENC_CW: begin
                        if (acc_q == ACC_TOP) begin
                            acc_d  = '0;
                            det_cw = 1'b1;
                        end else begin
                            acc_d = acc_q + 4'sd1;
                        end
                    end
                    RO_ENC_CCW: begin
                        if (acc_q == ACC_BOT) begin
                            acc_d   = '0;
                            det_ccw = 1'b1;
                        end else begin
                            acc_d = acc_q - 4'sd1;
                        end
                    end
                    RO_ENC_ERR: begin
                        acc_d = '0;
                        err_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if (det_cw && (cnt_d != CNT_MAX)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
        if (det_ccw && (cnt_d != CNT_MIN)) begin
            cnt_d = cnt_d - CNT_W'(1);
        end
    end

    always_comb begin
        data_d = RO_ENC_NONE;
        if (cnt_q[CNT_W-1]) begin
            data_d = RO_ENC_CCW;
        end else if (cnt_q != '0) begin
            data_d = RO_ENC_CW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
            cand_q  <= '0;
            run_q   <= '0;
            filt_q  <= '0;
            init_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            cand_q  <= sync2_q;
            run_q   <= run_d;
            filt_q  <= filt_d;
            init_q  <= init_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign data = data_q;
    assign cnt  = cnt_q;
    assign err  = err_q;

endmodule

// File: rtl/ro_enc_quad_multi.sv
// Multi-channel rotary-encoder decoder: CH_NUM independent channels plus a
// registered interrupt that stays up while any channel has a count or error.
module ro_enc_quad_multi #(
    parameter int unsigned CH_NUM   = 1,
    parameter int unsigned DEB_CYC  = 1000,
    parameter int unsigned STEP_DET = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CH_NUM-1:0]         i_ro_enc_state_a,
    input  logic [CH_NUM-1:0]         i_ro_enc_state_b,
    input  logic [CH_NUM-1:0]         i_sw_intr_clear,
    output logic [2*CH_NUM-1:0]       o_ro_enc_data,
    output logic [CH_NUM*CNT_W-1:0]   o_ro_enc_cnt,
    output logic [CH_NUM-1:0]         o_ro_enc_err,
    output logic                      o_intr
);

    logic [CH_NUM-1:0] pend;
    logic              intr_q;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        ro_enc_ch #(
            .DEB_CYC  (DEB_CYC),
            .STEP_DET (STEP_DET),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk        (i_clk),
            .rst_n      (i_rst),
            .enc_a      (i_ro_enc_state_a[k]),
            .enc_b      (i_ro_enc_state_b[k]),
            .intr_clear (i_sw_intr_clear[k]),
            .data       (o_ro_enc_data[2*k +: 2]),
            .cnt        (o_ro_enc_cnt[k*CNT_W +: CNT_W]),
            .err        (o_ro_enc_err[k])
        );

        assign pend[k] = (o_ro_enc_cnt[k*CNT_W +: CNT_W] != '0) | o_ro_enc_err[k];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= |pend;
        end
    end

    assign o_intr = intr_q;

endmodule
